// File: rtl/dmem_if.sv
// CPU load/store, video read and byte-wide memory signals gathered around dmem_arbiter.
// The arbiter sits on the slave side; requesters plus memory sit on the master side.
interface dmem_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        vga_req;
  logic [31:0] vga_addr;
  logic [7:0]  vga_rdata;
  logic        vga_done;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    output cpu_rdata, cpu_done, vga_rdata, vga_done, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    input  cpu_rdata, cpu_done, vga_rdata, vga_done, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a byte-wide data memory between CPU loads/stores and VGA reads.
// Define DMEM_BOUNDS_CHECK_EN to add cpu_err and suppress out-of-range accesses.
module dmem_arbiter #(
  parameter int unsigned MEM_DEPTH = 21
) (
  input  logic  clk,
  input  logic  rst_n,
  dmem_if.slave bus
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic  cpu_err
`endif
);
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CPU_XFER, VGA_XFER, DONE} state_e;

  state_e      state_q, state_d;
  logic        own_vga_q, own_vga_d;
  logic        last_cpu_q, last_cpu_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  vga_rdata_q, vga_rdata_d;
  logic        oob_q, oob_d;
  logic [31:0] asm_nxt;
  logic        last_byte;
  logic        vga_win;

  function automatic logic [2:0] nbytes(input logic [2:0] sz);
    case (sz)
      3'b000, 3'b100: nbytes = 3'd1;
      3'b001, 3'b101: nbytes = 3'd2;
      3'b010:         nbytes = 3'd4;
      default:        nbytes = 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] sz, input logic [31:0] v);
    case (sz)
      3'b000:  extend = {{24{v[7]}}, v[7:0]};
      3'b001:  extend = {{16{v[15]}}, v[15:0]};
      3'b100:  extend = {24'h0, v[7:0]};
      3'b101:  extend = {16'h0, v[15:0]};
      3'b010:  extend = v;
      default: extend = 32'h0;
    endcase
  endfunction

  // Any byte of the access past the end of memory, using wrapped 32-bit byte addresses.
  function automatic logic span_oob(input logic [31:0] a, input logic [2:0] n);
    span_oob = 1'b0;
    for (int k = 0; k < 4; k++)
      if (k < int'(n) && (a + 32'(k)) >= 32'(MEM_DEPTH)) span_oob = 1'b1;
  endfunction

  assign vga_win   = bus.vga_req && (!bus.cpu_req || last_cpu_q);
  assign last_byte = ({1'b0, cnt_q} == nbytes(size_q) - 3'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      own_vga_q   <= 1'b0;
      last_cpu_q  <= 1'b1;
      we_q        <= 1'b0;
      size_q      <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      asm_q       <= 32'h0;
      cnt_q       <= 2'd0;
      cpu_rdata_q <= 32'h0;
      vga_rdata_q <= 8'h0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_vga_q   <= own_vga_d;
      last_cpu_q  <= last_cpu_d;
      we_q        <= we_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      vga_rdata_q <= vga_rdata_d;
      oob_q       <= oob_d;
    end
  end

  // Zero-byte (invalid size) CPU requests skip the transfer state entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (vga_win)          state_d = VGA_XFER;
        else if (bus.cpu_req) state_d = (nbytes(bus.cpu_size) == 3'd0) ? DONE : CPU_XFER;
      end
      CPU_XFER: if (last_byte) state_d = DONE;
      VGA_XFER: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    own_vga_d   = own_vga_q;
    last_cpu_d  = last_cpu_q;
    we_d        = we_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    vga_rdata_d = vga_rdata_q;
    oob_d       = oob_q;
    asm_nxt     = asm_q;
    if (!we_q) asm_nxt[{cnt_q, 3'b000} +: 8] = bus.mem_rdata;
    case (state_q)
      IDLE: begin
        if (bus.vga_req || bus.cpu_req) begin
          own_vga_d  = vga_win;
          last_cpu_d = !vga_win;
          cnt_d      = 2'd0;
          asm_d      = 32'h0;
          if (vga_win) begin
            addr_d = bus.vga_addr;
          end else begin
            we_d    = bus.cpu_we;
            size_d  = bus.cpu_size;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
            oob_d   = BOUNDS_EN && span_oob(bus.cpu_addr, nbytes(bus.cpu_size));
            if (nbytes(bus.cpu_size) == 3'd0) cpu_rdata_d = 32'h0;
          end
        end
      end
      CPU_XFER: begin
        asm_d = asm_nxt;
        cnt_d = cnt_q + 2'd1;
        if (last_byte) begin
          if (oob_q)      cpu_rdata_d = 32'h0;
          else if (!we_q) cpu_rdata_d = extend(size_q, asm_nxt);
        end
      end
      VGA_XFER: vga_rdata_d = (BOUNDS_EN && addr_q >= 32'(MEM_DEPTH)) ? 8'h00 : bus.mem_rdata;
      default: ;
    endcase
  end

  // Strobes are gated by rst_n so a reset cycle can never write memory.
  always_comb begin
    bus.mem_addr  = 32'h0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 8'h00;
    bus.cpu_done  = 1'b0;
    bus.vga_done  = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
    cpu_err       = 1'b0;
`endif
    if (rst_n) begin
      case (state_q)
        CPU_XFER: begin
          bus.mem_addr  = addr_q + {30'h0, cnt_q};
          bus.mem_we    = we_q && !oob_q;
          bus.mem_wdata = we_q ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
        end
        VGA_XFER: bus.mem_addr = addr_q;
        DONE: begin
          bus.cpu_done = !own_vga_q;
          bus.vga_done = own_vga_q;
`ifdef DMEM_BOUNDS_CHECK_EN
          cpu_err      = !own_vga_q && oob_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vga_rdata = vga_rdata_q;
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_DEPTH, default 21, number of bytes in the shared byte-wide data memory.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 cpu_req  in  1  CPU load/store request, held high until cpu_done.
REQ-005 cpu_we  in  1  1 = store, 0 = load; stable while cpu_req is high.
REQ-006 cpu_size  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; stable while cpu_req is high.
REQ-007 cpu_addr  in  32  byte address; cpu_wdata  in  32  store data; both stable while cpu_req is high.
REQ-008 cpu_rdata  out  32  load result, valid in the cpu_done cycle.
REQ-009 cpu_done  out  1  one-cycle completion pulse.
REQ-010 vga_req  in  1  video byte-read request; vga_addr  in  32  byte address.
REQ-011 vga_rdata  out  8  read byte, valid in the vga_done cycle; vga_done  out  1  one-cycle pulse.
REQ-012 mem_addr  out  32, mem_we  out  1, mem_wdata  out  8  byte port to memory; mem_rdata  in  8  combinational read of mem_addr.

Function
REQ-013 FSM states: IDLE, CPU_XFER, VGA_XFER, DONE.
REQ-014 IDLE: with no request, stay in IDLE with mem_we=0.
REQ-015 IDLE: with exactly one request, grant it and go to the matching XFER state on the next edge.
REQ-016 IDLE, both requests: grant the requester not granted most recently (round-robin); after reset, CPU is treated as last granted, so VGA wins first.
REQ-017 Granted request fields are latched at grant; later changes are ignored until done.
REQ-018 CPU_XFER: transfer 1/2/4 bytes for byte/half/word at one byte per cycle, address cpu_addr+k for k=0..n-1 (little-endian).
REQ-019 CPU store byte k: mem_wdata = cpu_wdata[8k+7:8k], mem_we=1.
REQ-020 CPU load byte k: mem_rdata is captured into assembly register byte k, mem_we=0.
REQ-021 Load result: 000/001 sign-extend, 100/101 zero-extend, 010 takes all 32 bits.
REQ-022 VGA_XFER: one cycle, mem_we=0, mem_rdata captured into vga_rdata.
REQ-023 DONE: pulse the granted requester's done for exactly one cycle, then return to IDLE.
REQ-024 Latency from grant edge to done: n+1 cycles for CPU (n = byte count), 2 cycles for VGA.
REQ-025 A request still high in the IDLE cycle after done is a new request.
REQ-026 Invalid cpu_size (011, 110, 111): zero-byte transfer, no write, cpu_rdata=0, done after 1 cycle.
REQ-027 Byte addresses are computed as 32-bit sums; carry out of bit 31 is discarded.
REQ-028 mem_we is never high outside CPU_XFER with a store latched.
REQ-029 cpu_rdata and vga_rdata hold their last value until the next completion of the same requester.

Reset
REQ-030 While rst_n=0 at a clock edge: state←IDLE, all outputs 0, last-granted←CPU, byte counter 0, assembly register 0.
REQ-031 Reset mid-transfer aborts it: no done pulse; bytes already written stay in memory.

Configuration
REQ-032 Macro DMEM_BOUNDS_CHECK_EN, when defined, adds output cpu_err (1 bit, reset 0).
REQ-033 cpu_err is pulsed with cpu_done if any byte address ≥ MEM_DEPTH.
REQ-034 With DMEM_BOUNDS_CHECK_EN, an out-of-range CPU access suppresses every byte write of that access and returns cpu_rdata=0.
REQ-035 With DMEM_BOUNDS_CHECK_EN, a VGA read at an address ≥ MEM_DEPTH returns vga_rdata=0.
REQ-036 Without DMEM_BOUNDS_CHECK_EN there is no cpu_err port and addresses pass to memory unchecked.

Verification
REQ-037 SW addr 4 data 0xDEADBEEF -> mem writes 0xEF,0xBE,0xAD,0xDE at 4..7 on 4 consecutive cycles; cpu_done 5 cycles after grant.
REQ-038 Then LH addr 6 -> cpu_rdata 0xFFFFDEAD; LHU addr 6 -> 0x0000DEAD; LB addr 4 -> 0xFFFFFFEF.
REQ-039 cpu_req and vga_req rise together from reset -> VGA served first (vga_done after 2 cycles), then CPU; with both held, grants alternate.
REQ-040 rst_n low in the 2nd byte cycle of SW addr 0 data 0x11223344 -> byte 0 holds 0x44, byte 1 unchanged, no cpu_done.
REQ-041 With DMEM_BOUNDS_CHECK_EN: SW addr 19 -> cpu_err=1 with cpu_done, memory bytes 19..20 unchanged; without the macro, bytes 0x..44,0x33 land at 19,20.
REQ-042 cpu_size=011 -> cpu_done one cycle after grant, cpu_rdata=0, mem_we never asserted.
